// File: rtl/metronome_pkg.sv
// Shared constants and types for the metronome tempo path.
package metronome_pkg;

    localparam int BPM_MIN     = 20;
    localparam int BPM_MAX     = 300;
    localparam int BPM_DEFAULT = 120;
    localparam int BPM_W       = 9;
    localparam int PERIOD_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        OFFER
    } ctrl_state_t;

    // Beat period in clock cycles for the reset tempo.
    function automatic logic [PERIOD_W-1:0] default_period(input longint unsigned clk_hz);
        longint unsigned q;
        q = (clk_hz * 64'd60) / 64'(BPM_DEFAULT);
        return PERIOD_W'(q);
    endfunction

endpackage

// File: rtl/period_divider.sv
// Serial unsigned restoring divider: one quotient bit per cycle, DIVIDEND_W cycles per divide.
module period_divider #(
    parameter int unsigned DIVIDEND_W = 32,
    parameter int unsigned DIVISOR_W  = 9
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_done,
    output logic [DIVIDEND_W-1:0] o_quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic                  busy;
    logic [CNT_W-1:0]      count;
    logic [DIVIDEND_W-1:0] quo;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;
    logic [DIVISOR_W-1:0]  rem_next;
    logic [DIVIDEND_W-1:0] quo_next;
    logic                  last;

    // quo shifts dividend bits out the top while quotient bits enter at the bottom.
    always_comb begin
        trial    = {rem, quo[DIVIDEND_W-1]};
        fits     = (trial >= {1'b0, divisor});
        rem_next = fits ? DIVISOR_W'(trial - {1'b0, divisor}) : trial[DIVISOR_W-1:0];
        quo_next = {quo[DIVIDEND_W-2:0], fits};
        last     = (count == CNT_W'(DIVIDEND_W - 1));
    end

    assign o_done     = busy && last;
    assign o_quotient = quo_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (i_start) begin
            busy  <= 1'b1;
            count <= '0;
        end else if (busy) begin
            count <= count + 1'b1;
            if (last)
                busy <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_start) begin
            quo     <= i_dividend;
            rem     <= '0;
            divisor <= i_divisor;
        end else if (busy) begin
            quo <= quo_next;
            rem <= rem_next;
        end
    end

endmodule

// File: rtl/bpm_rate_controller.sv
// Merges button and UART tempo requests, clamps to a legal BPM and offers the matching beat period.
module bpm_rate_controller
    import metronome_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_btn_plus_1,
    input  logic                i_btn_plus_5,
    input  logic                i_btn_minus_1,
    input  logic                i_btn_minus_5,
    input  logic                i_uart_valid,
    input  logic [31:0]         i_uart_bpm,
    input  logic                i_period_ready,
    output logic                o_period_valid,
    output logic [PERIOD_W-1:0] o_period,
    output logic [BPM_W-1:0]    o_bpm,
    output logic                o_busy,
    output logic                o_uart_clamped
);

    localparam logic [PERIOD_W-1:0]     DIVIDEND     = PERIOD_W'(64'(CLK_HZ) * 64'd60);
    localparam logic [PERIOD_W-1:0]     RESET_PERIOD = default_period(64'(CLK_HZ));
    localparam logic signed [BPM_W+1:0] MIN_S        = (BPM_W+2)'(BPM_MIN);
    localparam logic signed [BPM_W+1:0] MAX_S        = (BPM_W+2)'(BPM_MAX);

    function automatic logic [BPM_W-1:0] clamp_bpm(input logic signed [BPM_W+1:0] v);
        if (v < MIN_S) return BPM_W'(BPM_MIN);
        if (v > MAX_S) return BPM_W'(BPM_MAX);
        return BPM_W'(v);
    endfunction

    function automatic logic uart_out_of_range(input logic [31:0] v);
        return (v < 32'(BPM_MIN)) || (v > 32'(BPM_MAX));
    endfunction

    function automatic logic [BPM_W-1:0] clamp_uart(input logic [31:0] v);
        if (v < 32'(BPM_MIN)) return BPM_W'(BPM_MIN);
        if (v > 32'(BPM_MAX)) return BPM_W'(BPM_MAX);
        return BPM_W'(v);
    endfunction

    function automatic logic signed [6:0] sat_delta(input logic signed [8:0] v);
        if (v > 9'sd63)  return 7'sd63;
        if (v < -9'sd63) return -7'sd63;
        return 7'(v);
    endfunction

    ctrl_state_t              state, state_next;
    logic signed [6:0]        delta;
    logic signed [8:0]        btn_sum, delta_sum;
    logic signed [BPM_W+1:0]  bpm_sum;
    logic                     uart_pending;
    logic [31:0]              uart_value;
    logic [BPM_W-1:0]         target, target_bpm;
    logic                     captured, clr_delta, clr_uart, clamp_hit;
    logic                     div_start, div_done;
    logic [PERIOD_W-1:0]      quotient;

    // Pulses landing on a clear-on-capture cycle start the fresh delta.
    always_comb begin
        btn_sum = '0;
        if (i_btn_plus_1)  btn_sum = btn_sum + 9'sd1;
        if (i_btn_plus_5)  btn_sum = btn_sum + 9'sd5;
        if (i_btn_minus_1) btn_sum = btn_sum - 9'sd1;
        if (i_btn_minus_5) btn_sum = btn_sum - 9'sd5;
        delta_sum = btn_sum + (clr_delta ? 9'sd0 : 9'(delta));
        bpm_sum   = $signed({2'b00, o_bpm}) + (BPM_W+2)'(delta);
    end

    always_comb begin
        state_next = state;
        target     = o_bpm;
        captured   = 1'b0;
        clr_delta  = 1'b0;
        clr_uart   = 1'b0;
        clamp_hit  = 1'b0;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                if (uart_pending) begin
                    target    = clamp_uart(uart_value);
                    clamp_hit = uart_out_of_range(uart_value);
                    clr_uart  = 1'b1;
                    clr_delta = 1'b1;
                    captured  = 1'b1;
                end else if (delta != 7'sd0) begin
                    target    = clamp_bpm(bpm_sum);
                    clr_delta = 1'b1;
                    captured  = 1'b1;
                end
                if (captured && (target != o_bpm)) begin
                    div_start  = 1'b1;
                    state_next = DIVIDE;
                end
            end
            DIVIDE:  if (div_done) state_next = OFFER;
            OFFER:   if (i_period_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_period_valid = (state == OFFER);
    assign o_busy         = (state != IDLE);

    period_divider #(
        .DIVIDEND_W(PERIOD_W),
        .DIVISOR_W (BPM_W)
    ) u_divider (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (div_start),
        .i_dividend(DIVIDEND),
        .i_divisor (target),
        .o_done    (div_done),
        .o_quotient(quotient)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= OFFER;
            delta          <= '0;
            uart_pending   <= 1'b0;
            o_uart_clamped <= 1'b0;
            o_bpm          <= BPM_W'(BPM_DEFAULT);
            o_period       <= RESET_PERIOD;
        end else begin
            state          <= state_next;
            delta          <= sat_delta(delta_sum);
            o_uart_clamped <= clamp_hit;
            if (i_uart_valid)
                uart_pending <= 1'b1;
            else if (clr_uart)
                uart_pending <= 1'b0;
            if ((state == DIVIDE) && div_done) begin
                o_bpm    <= target_bpm;
                o_period <= quotient;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_uart_valid)
            uart_value <= i_uart_bpm;
        if (div_start)
            target_bpm <= target;
    end

endmodule

// File: tb/tb_bpm_rate_controller.sv
// Scoreboard bench for bpm_rate_controller: expected offers queued at stimulus, checked at handshake.
module tb_bpm_rate_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p1 = 1'b0, p5 = 1'b0, m1 = 1'b0, m5 = 1'b0;
    logic        uv = 1'b0;
    logic [31:0] ub = '0;
    logic        ready = 1'b0;
    logic        valid;
    logic [31:0] period;
    logic [8:0]  bpm;
    logic        busy;
    logic        clamped;

    int checks = 0;
    int failures = 0;
    int clamp_pulses = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    bpm_rate_controller #(.CLK_HZ(50_000_000)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_btn_plus_1  (p1),
        .i_btn_plus_5  (p5),
        .i_btn_minus_1 (m1),
        .i_btn_minus_5 (m5),
        .i_uart_valid  (uv),
        .i_uart_bpm    (ub),
        .i_period_ready(ready),
        .o_period_valid(valid),
        .o_period      (period),
        .o_bpm         (bpm),
        .o_busy        (busy),
        .o_uart_clamped(clamped)
    );

    always @(negedge clk) if (clamped === 1'b1) clamp_pulses++;

    function automatic longint exp_period(input int b);
        return 64'd3_000_000_000 / longint'(b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic a1, input logic a5, input logic s1, input logic s5,
                         input logic u, input logic [31:0] uval);
        p1 = a1; p5 = a5; m1 = s1; m5 = s5; uv = u; ub = uval;
        @(negedge clk);
        p1 = 1'b0; p5 = 1'b0; m1 = 1'b0; m5 = 1'b0; uv = 1'b0;
    endtask

    task automatic wait_offer(input string tag, input int budget, output int cycles);
        logic [8:0]  b0;
        logic [31:0] p0;
        bit          moved;
        int          eb;
        b0 = bpm; p0 = period; moved = 0; cycles = 0;
        while (valid !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (valid !== 1'b1 && (bpm !== b0 || period !== p0)) moved = 1;
        end
        chk({tag, "_early_change"}, 64'(moved), 0);
        if (valid !== 1'b1) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_offer"}, 1, 0);
            return;
        end
        eb = exp_q.pop_front();
        chk({tag, "_bpm"}, 64'(bpm), 64'(eb));
        chk({tag, "_period"}, 64'(period), 64'(exp_period(eb)));
    endtask

    task automatic accept(input string tag);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(valid), 0);
        chk({tag, "_busy_drop"}, 64'(busy), 0);
    endtask

    task automatic quiet(input string tag, input int n, input bit check_busy);
        bit sv, sb;
        sv = 0; sb = 0;
        repeat (n) begin
            @(negedge clk);
            if (valid !== 1'b0) sv = 1;
            if (busy !== 1'b0) sb = 1;
        end
        chk({tag, "_no_offer"}, 64'(sv), 0);
        if (check_busy) chk({tag, "_stays_idle"}, 64'(sb), 0);
    endtask

    initial begin
        int cyc;
        int snap;
        bit moved;
        logic [31:0] p_hold;

        // reset values
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(valid), 1);
        chk("rst_bpm", 64'(bpm), 120);
        chk("rst_period", 64'(period), 25_000_000);
        chk("rst_busy", 64'(busy), 1);
        chk("rst_clamped", 64'(clamped), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(120);
        wait_offer("t1", 10, cyc);
        accept("t1");

        // +5 latency and result
        pulse(0, 1, 0, 0, 0, 0);
        exp_q.push_back(125);
        wait_offer("t2", 200, cyc);
        chk("t2_latency", 64'(cyc), 33);
        accept("t2");

        // UART out of range overrides a same-cycle button
        snap = clamp_pulses;
        pulse(1, 0, 0, 0, 1, 400);
        exp_q.push_back(300);
        wait_offer("t3", 200, cyc);
        accept("t3");
        quiet("t3", 60, 0);
        chk("t3_clamp_pulses", 64'(clamp_pulses - snap), 1);

        // presses at the limits are no-ops
        pulse(1, 0, 0, 0, 0, 0);
        quiet("t4_max", 40, 1);
        chk("t4_max_bpm", 64'(bpm), 300);
        snap = clamp_pulses;
        pulse(0, 0, 0, 0, 1, 5);
        exp_q.push_back(20);
        wait_offer("t4_low", 200, cyc);
        accept("t4_low");
        chk("t4_low_clamp_pulses", 64'(clamp_pulses - snap), 1);
        pulse(0, 0, 0, 1, 0, 0);
        quiet("t4_min", 40, 1);
        chk("t4_min_bpm", 64'(bpm), 20);

        // requests during DIVIDE accumulate; outputs hold while ready is low
        pulse(0, 1, 0, 0, 0, 0);
        exp_q.push_back(25);
        repeat (4) @(negedge clk);
        pulse(1, 0, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 0);
        pulse(0, 0, 0, 1, 0, 0);
        pulse(1, 0, 0, 0, 0, 0);
        exp_q.push_back(23);
        wait_offer("t5a", 200, cyc);
        p_hold = period;
        moved = 0;
        repeat (100) begin
            @(negedge clk);
            if (period !== p_hold || valid !== 1'b1 || bpm !== 9'd25) moved = 1;
        end
        chk("t5_hold_stable", 64'(moved), 0);
        accept("t5a");
        wait_offer("t5b", 200, cyc);
        accept("t5b");
        quiet("t5", 60, 0);

        // async reset mid-divide discards the pending UART request
        pulse(1, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        pulse(0, 0, 0, 0, 1, 60);
        repeat (3) @(negedge clk);
        chk("t6_busy_before", 64'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(valid), 1);
        chk("t6_rst_bpm", 64'(bpm), 120);
        chk("t6_rst_period", 64'(period), 25_000_000);
        chk("t6_rst_busy", 64'(busy), 1);
        chk("t6_rst_clamped", 64'(clamped), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(120);
        wait_offer("t6", 10, cyc);
        accept("t6");
        quiet("t6", 60, 0);
        chk("t6_final_bpm", 64'(bpm), 120);
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
